// File: rtl/frac_clk_gen.sv
// Multi-channel phase-accumulator clock generator.
// Each channel retunes only on its own carry, so outputs never emit runt pulses.
module frac_clk_gen #(
   parameter int CHANNELS = 2,
   parameter int ACC_W    = 10,
   parameter int INC_RST0 = 179,
   parameter int INC_RST1 = 256,
   parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_inc,
   input  logic                wr_en,
   input  logic [CW-1:0]       wr_ch,
   input  logic [ACC_W-1:0]    wdata,
   input  logic [CW-1:0]       rd_ch,
   output logic [ACC_W+1:0]    rdata,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] tick
);

   logic [ACC_W+1:0] ch_rd [CHANNELS];
   logic [ACC_W+1:0] rd_nxt;

   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      localparam logic [ACC_W-1:0] INC_RST =
         (n == 0) ? ACC_W'(INC_RST0) :
         (n == 1) ? ACC_W'(INC_RST1) : '0;

      logic [ACC_W-1:0] acc;
      logic [ACC_W-1:0] inc_act;
      logic [ACC_W-1:0] inc_pend;
      logic             pend_valid;
      logic             en;
      logic             tick_q;
      logic             sel;
      logic             load;
      logic             en_nxt;
      logic [ACC_W:0]   sum;

      assign sel    = (wr_ch == CW'(n));
      assign load   = sel & wr_inc;
      // a same-cycle enable write decides how a load is treated
      assign en_nxt = (sel & wr_en) ? wdata[0] : en;
      assign sum    = {1'b0, acc} + {1'b0, inc_act};

      always_ff @(posedge clk) begin
         if (reset) begin
            acc        <= '0;
            inc_act    <= INC_RST;
            inc_pend   <= '0;
            pend_valid <= 1'b0;
            en         <= 1'b1;
            tick_q     <= 1'b0;
         end else if (!en_nxt) begin
            acc        <= '0;
            tick_q     <= 1'b0;
            en         <= 1'b0;
            pend_valid <= 1'b0;
            if (load)
               inc_act <= wdata;
            else if (pend_valid)
               inc_act <= inc_pend;
         end else if (!en) begin
            acc    <= '0;
            tick_q <= 1'b0;
            en     <= 1'b1;
            if (load) begin
               inc_pend   <= wdata;
               pend_valid <= 1'b1;
            end
         end else begin
            acc    <= sum[ACC_W-1:0];
            tick_q <= sum[ACC_W];
            // promotion at the wrap; the wrapping add used the old value
            if (sum[ACC_W] && pend_valid)
               inc_act <= inc_pend;
            if (load) begin
               inc_pend   <= wdata;
               pend_valid <= 1'b1;
            end else if (sum[ACC_W]) begin
               pend_valid <= 1'b0;
            end
         end
      end

      assign clk_out[n] = acc[ACC_W-1];
      assign tick[n]    = tick_q;
      assign ch_rd[n]   = {pend_valid, en, inc_act};
   end

   always_comb begin
      rd_nxt = '0;
      for (int n = 0; n < CHANNELS; n++)
         if (rd_ch == CW'(n))
            rd_nxt = ch_rd[n];
   end

   always_ff @(posedge clk) begin
      if (reset)
         rdata <= '0;
      else
         rdata <= rd_nxt;
   end

endmodule

// File: doc/frac_clk_gen.md
# frac_clk_gen

Multi-channel programmable fractional clock generator. It replaces the fixed divide-by-4 and 179/1024 dividers on the COM-AY board with N phase-accumulator channels. Each channel has a runtime-loadable increment, an enable bit, and glitch-free retuning. Channel 0 feeds the AY clock and channel 1 the ВИ53/ВВ51 clock; the port decoder drives the write/read strobes.

## Interface
- CHANNELS, 2, number of independent clock channels (1..8)
- ACC_W, 10, accumulator width; output frequency = f_clk * inc / 2^ACC_W
- INC_RST0, 179, reset increment of channel 0 (1.748 MHz from 10 MHz)
- INC_RST1, 256, reset increment of channel 1 (÷4, 2.5 MHz); channels ≥2 reset to 0
- CW, $clog2(CHANNELS) (min 1), channel-select width

Ports:
- clk  in  1  system clock, 10 MHz Orion clock; single clock domain
- reset  in  1  synchronous, active-high reset
- wr_inc  in  1  one-cycle strobe: load wdata as pending increment of channel wr_ch
- wr_en  in  1  one-cycle strobe: load wdata[0] as enable of channel wr_ch
- wr_ch  in  CW  target channel for writes
- wdata  in  ACC_W  write data
- rd_ch  in  CW  channel selected for readback
- rdata  out  ACC_W+2  {pend_valid, en, active_inc} of rd_ch, registered
- clk_out  out  CHANNELS  per-channel generated clock = accumulator MSB
- tick  out  CHANNELS  one-cycle pulse on accumulator carry-out

## Operation
- Per-channel state: acc[ACC_W-1:0], inc_act, inc_pend, pend_valid, en.
- Reset values: acc=0, inc_act=INC_RSTn, inc_pend=0, pend_valid=0, en=1; clk_out=0, tick=0, rdata=0.
- Running (en=1): {carry, acc} <= acc + inc_act (ACC_W+1-bit add, wraps modulo 2^ACC_W); tick <= carry.
- clk_out[n] = acc[n][ACC_W-1], taken directly from the flop with no combinational path.
- Disabled (en=0): acc held at 0, tick=0, clk_out=0.
- wr_inc on an enabled channel sets inc_pend=wdata and pend_valid=1. Pending becomes active on the first cycle whose add produces carry=1.
  - That cycle's sum still uses the old inc_act.
  - From the next cycle on, inc_act=inc_pend and pend_valid=0.
  - The retune therefore happens at a phase boundary, with no runt pulse.
- wr_inc on a disabled channel loads inc_act directly; pend_valid stays 0.
- Repeated wr_inc before the wrap: the last write wins.
- wr_inc in the same cycle as the carry that promotes an older pending value:
  - the older value goes active;
  - the new write is kept as pending, pend_valid=1.
- wr_en with wdata[0]=0 clears en. The next cycle has acc=0; any pending value is promoted immediately.
- wr_en with wdata[0]=1 on a disabled channel: the accumulator starts from 0 the following cycle. On an enabled channel it has no effect.
- inc_act=0: acc frozen, no ticks, clk_out static.
- wr_ch or rd_ch ≥ CHANNELS: writes are ignored; reads return 0.
- wr_inc and wr_en together on the same channel: both take effect. The enable change is evaluated first, so a disable+load loads inc_act directly.

## Timing
- Write strobe at edge k: register state changes at edge k+1; accumulator effect is visible from edge k+2.
- tick is asserted in the cycle after the overflowing add. It is exactly one clk wide and aligned with the acc value after the wrap.
- clk_out duty cycle: exactly 50% when inc divides 2^ACC_W; otherwise jitter is at most 1 clk.
- rdata: 1-cycle latency from rd_ch.
- Reset asserted mid-operation: all state returns to reset values at the next edge, and outputs are 0 in that cycle.

## Test plan
- Reset, run 1024 clk: clk_out[0] shows exactly 179 rising edges and tick[0] 179 pulses; clk_out[1] has period 4 clk, 2 high/2 low, 256 edges.
- While running, wr_inc ch1=512: inc_act stays 256 until the first tick[1]; after that, clk_out[1] has period 2 and rdata shows pend_valid=0, active=512.
- wr_en ch0=0: next cycle acc0=0 and clk_out[0]=0 with no ticks. wr_inc ch0=7 then loads directly (rdata active=7, pend_valid=0). wr_en=1: first tick after ceil(1024/7)=147 clk.
- wr_inc ch1=128 issued in the same cycle as a carry promoting pending 512: 512 goes active, 128 remains pending, and 128 goes active at the following carry.
- wr_inc ch0=0: after promotion the accumulator freezes with no further ticks. Then assert reset mid-run: all outputs 0 and defaults restored (rdata ch0 = {0,1,179}).
- Writes to wr_ch=CHANNELS (CHANNELS=3 build) are ignored and reads return 0; ch2 resets to inc 0 and stays silent.
